// File: rtl/ysyx_2022040010_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, stage index constants and default parameter values.
package ysyx_2022040010_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REPLAY   = 2'd2
  } pc_state_e;

  localparam int NSTAGE_DEF    = 5;
  localparam int EX_STAGE_DEF  = 2;
  localparam int MEM_STAGE_DEF = 3;
  localparam int PC_W_DEF      = 32;
  localparam int TMO_W_DEF     = 8;

  // Stage indices fixed by the pipeline shape (IF=0, ID=1).
  localparam int STAGE_IF = 0;
  localparam int STAGE_ID = 1;

  // Stall/flush bus for the default pipeline depth.
  typedef logic [NSTAGE_DEF-1:0] stall_bus_t;

endpackage

// File: rtl/ysyx_2022040010_pipe_ctrl_wdt.sv
// Miss watchdog: saturating counter with synchronous clear and count
// enable, plus a sticky flag that rises when the counter reaches its
// maximum value (2**W-1) and stays set until reset.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr_i     clear the counter (flag is unaffected)
//   en_i      count one wait cycle
//   flag_o    sticky timeout flag (registered)
module ysyx_2022040010_wdt #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic flag_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         flag_q, flag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Flag rises on the same edge the counter reaches its maximum.
    flag_d = flag_q | (cnt_d == CNT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Pipeline hazard controller. Merges branch redirect, multi-cycle EX busy,
// load-use and memory-miss requests into per-stage stall/flush vectors and
// a redirect PC. A redirect arriving while memory is outstanding is parked
// in a pending register and replayed the cycle after the memory ack.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_redirect, redirect_pc  EX redirect pulse and target
//   req_ex_busy, req_load_use  level hazards
//   req_mem, mem_ack           memory request (held) and completion
//   stall, flush               per-stage hold / bubble (combinational)
//   new_pc_valid, new_pc       fetch redirect (combinational)
//   timeout                    sticky watchdog error (registered)
module ysyx_2022040010_pipe_ctrl
  import ysyx_2022040010_pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = NSTAGE_DEF,
  parameter int EX_STAGE  = EX_STAGE_DEF,
  parameter int MEM_STAGE = MEM_STAGE_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int TMO_W     = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              req_ex_busy,
  input  logic              req_load_use,
  input  logic              req_mem,
  input  logic              mem_ack,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              new_pc_valid,
  output logic [PC_W-1:0]   new_pc,
  output logic              timeout
);

  pc_state_e         state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;

  logic [NSTAGE-1:0] stall_c, flush_c;
  logic              npv_c;
  logic [PC_W-1:0]   npc_c;
  logic              wdt_en, wdt_clr;

  // Hold-to-S: stages 0..S hold, stage S+1 takes a bubble.
  function automatic logic [NSTAGE-1:0] hold_stall(input int s);
    logic [NSTAGE-1:0] r;
    for (int k = 0; k < NSTAGE; k++) r[k] = (k <= s);
    return r;
  endfunction

  function automatic logic [NSTAGE-1:0] hold_flush(input int s);
    logic [NSTAGE-1:0] r;
    for (int k = 0; k < NSTAGE; k++) r[k] = (k == s + 1);
    return r;
  endfunction

  // Redirect squashes every stage younger than EX.
  function automatic logic [NSTAGE-1:0] front_flush();
    logic [NSTAGE-1:0] r;
    for (int k = 0; k < NSTAGE; k++) r[k] = (k < EX_STAGE);
    return r;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    stall_c      = '0;
    flush_c      = '0;
    npv_c        = 1'b0;
    npc_c        = '0;
    wdt_en       = 1'b0;
    wdt_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_mem && !mem_ack) begin
          stall_c = hold_stall(MEM_STAGE);
          flush_c = hold_flush(MEM_STAGE);
          state_d = ST_MEM_WAIT;
          // The memory op is older than the redirecting EX op: park it.
          if (req_redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc;
          end
        end else if (req_redirect) begin
          flush_c = front_flush();
          npv_c   = 1'b1;
          npc_c   = redirect_pc;
        end else if (req_ex_busy) begin
          stall_c = hold_stall(EX_STAGE);
          flush_c = hold_flush(EX_STAGE);
        end else if (req_load_use) begin
          stall_c = hold_stall(STAGE_ID);
          flush_c = hold_flush(STAGE_ID);
        end
      end

      ST_MEM_WAIT: begin
        // EX is frozen while waiting, so only the first pulse is real.
        if (req_redirect && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
        if (mem_ack) begin
          wdt_clr = 1'b1;
          state_d = pend_valid_d ? ST_REPLAY : ST_IDLE;
        end else begin
          stall_c = hold_stall(MEM_STAGE);
          flush_c = hold_flush(MEM_STAGE);
          wdt_en  = 1'b1;
        end
      end

      ST_REPLAY: begin
        flush_c      = front_flush();
        npv_c        = 1'b1;
        npc_c        = pend_pc_q;
        pend_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the pending PC is reset along with its valid bit; it is a single
  // register, not a memory array, so the reset costs nothing meaningful and
  // keeps new_pc free of X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  ysyx_2022040010_wdt #(
    .W(TMO_W)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (wdt_clr),
    .en_i   (wdt_en),
    .flag_o (timeout)
  );

  // Requests are live during reset, so the decode is forced quiet.
  assign stall        = rst ? '0 : stall_c;
  assign flush        = rst ? '0 : flush_c;
  assign new_pc_valid = rst ? 1'b0 : npv_c;
  assign new_pc       = rst ? '0 : npc_c;

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
module tb_ysyx_2022040010_pipe_ctrl;

  localparam int NS    = 5;
  localparam int EX    = 2;
  localparam int MEM   = 3;
  localparam int ID    = 1;
  localparam int TMO_W = 3;
  localparam int CMAX  = (1 << TMO_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          req_ex_busy = 1'b0;
  logic          req_load_use = 1'b0;
  logic          req_mem = 1'b0;
  logic          mem_ack = 1'b0;
  logic [NS-1:0] stall, flush;
  logic          new_pc_valid;
  logic [31:0]   new_pc;
  logic          timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_pipe_ctrl #(
    .NSTAGE(NS), .EX_STAGE(EX), .MEM_STAGE(MEM), .PC_W(32), .TMO_W(TMO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_redirect (req_redirect),
    .redirect_pc  (redirect_pc),
    .req_ex_busy  (req_ex_busy),
    .req_load_use (req_load_use),
    .req_mem      (req_mem),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .flush        (flush),
    .new_pc_valid (new_pc_valid),
    .new_pc       (new_pc),
    .timeout      (timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [NS-1:0] hold_mask(input int s);
    return NS'((1 << (s + 1)) - 1);
  endfunction
  function automatic logic [NS-1:0] bubble_at(input int s);
    return NS'(1 << (s + 1));
  endfunction
  localparam logic [NS-1:0] FRONT = NS'((1 << EX) - 1);

  bit          m_wait, m_pend, m_replay, m_tmo;
  logic [31:0] m_pend_pc;
  int          m_cnt;

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_wait = 0; m_pend = 0; m_replay = 0; m_tmo = 0; m_cnt = 0; m_pend_pc = '0;
    end else if (m_replay) begin
      m_replay = 0;
      m_pend   = 0;
    end else if (m_wait) begin
      if (req_redirect && !m_pend) begin
        m_pend = 1; m_pend_pc = redirect_pc;
      end
      if (mem_ack) begin
        m_cnt = 0; m_wait = 0; m_replay = m_pend;
      end else begin
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_cnt == CMAX) m_tmo = 1;
      end
    end else if (req_mem && !mem_ack) begin
      m_wait = 1;
      if (req_redirect) begin
        m_pend = 1; m_pend_pc = redirect_pc;
      end
    end
  end

  // Compare process: every negedge, outputs against the model.
  always @(negedge clk) begin
    logic [NS-1:0] e_st, e_fl;
    logic          e_v, e_t;
    logic [31:0]   e_pc;
    e_st = '0; e_fl = '0; e_v = 0; e_pc = '0;
    e_t  = rst ? 1'b0 : m_tmo;
    if (rst) begin
      // all quiet
    end else if (m_replay) begin
      e_fl = FRONT; e_v = 1; e_pc = m_pend_pc;
    end else if (m_wait) begin
      if (!mem_ack) begin e_st = hold_mask(MEM); e_fl = bubble_at(MEM); end
    end else if (req_mem && !mem_ack) begin
      e_st = hold_mask(MEM); e_fl = bubble_at(MEM);
    end else if (req_redirect) begin
      e_fl = FRONT; e_v = 1; e_pc = redirect_pc;
    end else if (req_ex_busy) begin
      e_st = hold_mask(EX); e_fl = bubble_at(EX);
    end else if (req_load_use) begin
      e_st = hold_mask(ID); e_fl = bubble_at(ID);
    end
    check("model_stall", 64'(stall), 64'(e_st));
    check("model_flush", 64'(flush), 64'(e_fl));
    check("model_npv", 64'(new_pc_valid), 64'(e_v));
    check("model_new_pc", 64'(new_pc), 64'(e_pc));
    check("model_timeout", 64'(timeout), 64'(e_t));
  end

  // Drive one cycle of inputs after the edge, then wait to a sampling point.
  task automatic step(input logic r, input logic lu, input logic ex, input logic rd,
                      input logic [31:0] pc, input logic mem, input logic ack);
    @(posedge clk);
    #1;
    rst = r; req_load_use = lu; req_ex_busy = ex; req_redirect = rd;
    redirect_pc = pc; req_mem = mem; mem_ack = ack;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit mem_busy;
    bit r, lu, ex, rd, mem, ack;

    // Reset state
    @(negedge clk); #1;
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_timeout", 64'(timeout), 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("idle_stall", 64'(stall), 64'h0);

    // 1. load-use one cycle
    step(0, 1, 0, 0, 0, 0, 0);
    check("lu_stall", 64'(stall), 64'b00011);
    check("lu_flush", 64'(flush), 64'b00100);
    step(0, 0, 0, 0, 0, 0, 0);
    check("lu_after", 64'(stall | flush), 64'h0);

    // 2. ex_busy four cycles
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      check("ex_stall", 64'(stall), 64'b00111);
      check("ex_flush", 64'(flush), 64'b01000);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("ex_after", 64'(stall | flush), 64'h0);

    // 3. redirect in IDLE
    step(0, 0, 0, 1, 32'h8000_0040, 0, 0);
    check("rd_flush", 64'(flush), 64'b00011);
    check("rd_stall", 64'(stall), 64'h0);
    check("rd_npv", 64'(new_pc_valid), 64'h1);
    check("rd_pc", 64'(new_pc), 64'h8000_0040);

    // 4. memory miss, redirect parked at wait cycle 2, ack after 6 cycles
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, i == 2, 32'h100, 1, 0);
      check("mw_stall", 64'(stall), 64'b01111);
      check("mw_flush", 64'(flush), 64'b10000);
      check("mw_npv", 64'(new_pc_valid), 64'h0);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    check("ack_zero", 64'({stall, flush, new_pc_valid}), 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rep_flush", 64'(flush), 64'b00011);
    check("rep_npv", 64'(new_pc_valid), 64'h1);
    check("rep_pc", 64'(new_pc), 64'h100);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rep_after", 64'({flush, new_pc_valid}), 64'h0);

    // 5. hit plus load-use
    step(0, 1, 0, 0, 0, 1, 1);
    check("hit_stall", 64'(stall), 64'b00011);
    check("hit_flush", 64'(flush), 64'b00100);
    step(0, 0, 0, 0, 0, 0, 0);
    check("hit_idle", 64'(stall | flush), 64'h0);

    // 6. watchdog with TMO_W=3, then reset mid-wait with a parked redirect
    step(0, 0, 0, 0, 0, 1, 0);
    for (int j = 1; j <= 10; j++) begin
      step(0, 0, 0, j == 2, 32'h200, 1, 0);
      check("wd_stall", 64'(stall), 64'b01111);
      if (j == 7) check("wd_tmo_lo", 64'(timeout), 64'h0);
      if (j == 8) check("wd_tmo_hi", 64'(timeout), 64'h1);
    end
    step(1, 0, 0, 0, 0, 1, 0);
    check("rstm_out", 64'({stall, flush, new_pc_valid}), 64'h0);
    check("rstm_tmo", 64'(timeout), 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("norep_1", 64'({flush, new_pc_valid}), 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("norep_2", 64'({flush, new_pc_valid}), 64'h0);

    // Randomized phase: memory protocol respected, model compares each cycle.
    mem_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 299) == 0);
      mem = mem_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
      ack = mem && ($urandom_range(0, 5) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      ex  = ($urandom_range(0, 3) == 0);
      lu  = ($urandom_range(0, 3) == 0);
      step(r, lu, ex, rd, $urandom, mem, ack);
      mem_busy = mem && !ack && !r;
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
